// File: rtl/sysctrl_irq.sv
// sysctrl_irq: system control register block for the management SoC bus.
// Holds the user wishbone interface enable and N_IRQ user interrupt channels,
// each with a 2-flop synchroniser (plus an edge-detect flop), a per-channel
// level/edge mode, sticky write-1-to-clear pending bits (edge mode) and
// enable-gated interrupt outputs.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   iomem_*            simple valid/ready register bus (wstrb == 0 is a read)
//   user_irq_in        asynchronous interrupt requests from the user area
//   user_irq_ena       enable register contents
//   mprj_wb_iena       user wishbone interface enable
//   user_irq           pending & enable, per channel
//   irq_any            OR of user_irq
module sysctrl_irq #(
    parameter logic [31:0] BASE_ADR = 32'h2300_0000,
    parameter int unsigned N_IRQ    = 3,
    parameter logic [7:0]  IRQ_ENA  = 8'h00,
    parameter logic [7:0]  WB_ENA   = 8'h04,
    parameter logic [7:0]  IRQ_EDGE = 8'h08,
    parameter logic [7:0]  IRQ_RAW  = 8'h0C,
    parameter logic [7:0]  IRQ_PEND = 8'h10,
    parameter logic [7:0]  IRQ_STAT = 8'h14
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      iomem_addr,
    input  logic             iomem_valid,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic             iomem_ready,
    input  logic [N_IRQ-1:0] user_irq_in,
    output logic [N_IRQ-1:0] user_irq_ena,
    output logic             mprj_wb_iena,
    output logic [N_IRQ-1:0] user_irq,
    output logic             irq_any
);

    logic [N_IRQ-1:0] ena_q, edge_q, pend_q;
    logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
    logic             wb_q;
    logic             ready_q;
    logic [31:0]      rdata_q;

    logic             accept, wr;
    logic [7:0]       off;
    logic [31:0]      bmask;
    logic [N_IRQ-1:0] wmask, wbits;
    logic [N_IRQ-1:0] ena_d, edge_d, pend_d, clr;
    logic             wb_d;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    // Ready being high blocks acceptance, so a held request is re-accepted
    // only every second cycle.
    assign accept = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_ADR[31:8]);
    assign wr     = accept && (iomem_wstrb != 4'b0000);
    assign off    = iomem_addr[7:0];
    assign bmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wmask  = bmask[N_IRQ-1:0];
    assign wbits  = iomem_wdata[N_IRQ-1:0];

    assign unused_bits = ^{iomem_wdata, bmask};

    always_comb begin
        rd_mux = '0;
        case (off)
            IRQ_ENA:  rd_mux = 32'(ena_q);
            WB_ENA:   rd_mux = {31'b0, wb_q};
            IRQ_EDGE: rd_mux = 32'(edge_q);
            IRQ_RAW:  rd_mux = 32'(s2_q);
            IRQ_PEND: rd_mux = 32'(pend_q);
            IRQ_STAT: rd_mux = 32'(pend_q & ena_q);
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        ena_d  = ena_q;
        edge_d = edge_q;
        wb_d   = wb_q;
        clr    = '0;
        if (wr) begin
            if (off == IRQ_ENA)
                ena_d = (ena_q & ~wmask) | (wbits & wmask);
            if (off == IRQ_EDGE)
                edge_d = (edge_q & ~wmask) | (wbits & wmask);
            if (off == WB_ENA && iomem_wstrb[0])
                wb_d = iomem_wdata[0];
            if (off == IRQ_PEND)
                clr = wmask & wbits;
        end
        // Edge channels: sticky, a new rising edge wins over a same-cycle W1C.
        // Level channels: follow the synchronised input.
        pend_d = (edge_q & ((pend_q & ~clr) | (s2_q & ~s3_q))) | (~edge_q & s2_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ena_q   <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            wb_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            s1_q    <= user_irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            ena_q   <= ena_d;
            edge_q  <= edge_d;
            wb_q    <= wb_d;
            pend_q  <= pend_d;
            ready_q <= accept;
            if (accept)
                rdata_q <= rd_mux;
        end
    end

    assign iomem_ready  = ready_q;
    assign iomem_rdata  = rdata_q;
    assign user_irq_ena = ena_q;
    assign mprj_wb_iena = wb_q;
    assign user_irq     = pend_q & ena_q;
    assign irq_any      = |(pend_q & ena_q);

endmodule

// File: doc/sysctrl_irq.md
# sysctrl_irq

Parametrised successor to the system control register block between the management SoC bus and the management protect block. Holds the user-wishbone interface enable and a configurable number of user IRQ channels. Each channel has a 2-flop synchroniser, per-channel level/edge mode and sticky write-1-to-clear pending bits. It also drives masked per-channel and combined interrupt outputs toward the CPU.

## Interface
- BASE_ADR, 32'h2300_0000: block base; bits [31:8] decode, bits [7:0] select the register.
- N_IRQ, 3: number of user IRQ channels, 1..32.
- IRQ_ENA, 8'h00: offset of the IRQ enable register (RW).
- WB_ENA, 8'h04: offset of the wishbone enable register (RW, bit 0 only).
- IRQ_EDGE, 8'h08: offset of the mode register (RW; 1 = rising-edge, 0 = level).
- IRQ_RAW, 8'h0C: offset of the synchronised raw inputs (RO).
- IRQ_PEND, 8'h10: offset of the pending register (R/W1C).
- IRQ_STAT, 8'h14: offset of the status register, pending & enable (RO).

- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- iomem_addr  in  32  byte address.
- iomem_valid  in  1  request valid.
- iomem_wstrb  in  4  byte write strobes; all zero = read.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  registered read data.
- iomem_ready  out  1  one-cycle completion pulse.
- user_irq_in  in  N_IRQ  asynchronous interrupt requests from the user area.
- user_irq_ena  out  N_IRQ  enable register contents.
- mprj_wb_iena  out  1  user wishbone interface enable.
- user_irq  out  N_IRQ  pending & enable, per channel.
- irq_any  out  1  OR-reduction of user_irq.

## Operation
- **Reset.** Asserting resetn low clears every register and output to 0 immediately, independent of clk. This covers the enable, mode, pending and synchroniser flops, iomem_ready and iomem_rdata. A transaction in flight is dropped; the bus master must re-issue it.
- **Accept.** A request is accepted when iomem_valid && !iomem_ready && iomem_addr[31:8] == BASE_ADR[31:8].
  - Addresses outside the base are ignored: no ready, no state change.
- **Read.** At the accepting edge, iomem_ready goes to 1 and iomem_rdata loads the selected register, zero-extended to 32 bits.
  - An unmapped offset inside the base still gets ready, with rdata = 0.
- **Write.** Strobe iomem_wstrb[b] writes bits [8b+7:8b] of the selected register, limited to implemented bits.
  - Bits at N_IRQ and above read 0 and ignore writes.
  - Writes to IRQ_RAW and IRQ_STAT are ignored.
- **Read-then-write.** A write access returns the register value from before the write.
- **Synchroniser.** Chain per channel: s1 <= user_irq_in, s2 <= s1, s3 <= s2. IRQ_RAW reads s2.
- **Pending, level mode (edge bit 0).** pend <= s2. Writes to PEND have no effect on that bit.
- **Pending, edge mode (edge bit 1).**
  - pend sets when s2 & ~s3.
  - Writing 1 to a pend bit (strobe byte active) clears it; writing 0 has no effect.
  - If a set and a clear land on the same edge, set wins (bit stays 1).
- **Mode change.** Switching level->edge keeps the current pend value as sticky. Switching edge->level makes pend follow s2 from the next edge.
- **Enable gating.** Enables gate only the outputs, never pend capture. A disabled channel still latches edges and fires once it is enabled.
- **Outputs.** user_irq = pend & user_irq_ena and irq_any = |user_irq, both combinational from registers.

## Timing
- **Bus latency.** iomem_ready rises at the first edge after valid is sampled and stays high for exactly one cycle. It is forced low on the next edge, even if valid is still held.
- **Back-to-back access.** A held-valid master is re-accepted every second cycle.
- **Write visibility.** Written values appear on outputs and in read data from the accepting edge onward.
- **IRQ latency.** With user_irq_in rising before edge k: s1 = 1 at k, s2 = 1 at k+1, pend = 1 at k+2 (both modes). user_irq and irq_any follow combinationally after k+2.
- **Minimum pulse.** An edge-mode pulse must be at least one clk period wide to be captured. Narrower pulses may be missed.
- **W1C vs. re-set.** A W1C accepted at edge j clears pend at j. A new rising edge with s2 & ~s3 true at j keeps pend at 1.
- **Reset release.** Reset release is synchronised externally. The first request may be accepted on the first edge after release.

## Test plan
- **Reset values.** Assert resetn mid-read with ready high -> ready, rdata, enables, pend and user_irq all 0 immediately. After release, reading IRQ_ENA returns 0.
- **Register access.** N_IRQ=3. Write IRQ_ENA = 32'hFFFF_FFFF with wstrb 4'b0001 -> readback 32'h7, user_irq_ena = 3'b111. Write WB_ENA = 1 with wstrb 0 -> read 0, mprj_wb_iena stays 0.
- **Edge capture and W1C.** Channel 1 in edge mode, enabled; pulse user_irq_in[1] for 2 cycles -> pend[1] = 1 two edges after s1 captures it, user_irq = 3'b010, irq_any = 1. Input low; write PEND = 32'h2 -> pend cleared, irq_any = 0.
- **Simultaneous set/clear.** Time a W1C of channel 0 to land on the same edge as a new s2 & ~s3 -> pend[0] stays 1.
- **Level mode and gating.** Channel 2 in level mode, enable 0; hold input high -> IRQ_RAW bit2 = 1, PEND bit2 = 1, STAT = 0, user_irq[2] = 0. Set enable -> user_irq[2] = 1. W1C -> no effect. Drop input -> pend clears 3 edges later.
- **Decode and handshake.** Access base+0x40 -> ready, rdata 0. Access with addr[31:8] != BASE_ADR[31:8] -> no ready. Hold valid 4 cycles on IRQ_ENA -> ready pattern 1,0,1,0.
